// File: rtl/blk3_chunk_sequencer.sv
// Packs a little-endian 32-bit word stream into 16-word BLAKE3 blocks and drives one
// HashGen compression per block, chaining H from IV; single-chunk messages only.
module blk3_chunk_sequencer #(
  parameter int MAX_BLOCKS = 16
) (
  input  logic              Clk,
  input  logic              Rstn_I,
  input  logic [31:0]       Word_I,
  input  logic              WVld_I,
  input  logic              Last_I,
  input  logic [2:0]        LastBytes_I,
  output logic              WRdy_O,
  output logic              Strt_O,
  output logic [31:0]       BL_O,
  output logic              CS_flg_O,
  output logic              CE_flg_O,
  output logic              ROOT_flg_O,
  output logic [7:0][31:0]  H_O,
  output logic [15:0][31:0] Msg_O,
  input  logic              Vld_I,
  input  logic [7:0][31:0]  H_I,
  output logic [7:0][31:0]  Dig_O,
  output logic              DVld_O,
  output logic              Err_O,
  output logic [2:0]        Dbg_State_O
);

  // Handshake: a beat transfers on a rising edge where WVld_I & WRdy_O; HashGen takes
  // a one-cycle Strt_O and answers with a one-cycle Vld_I, which counts only in HASH.
  localparam logic [7:0][31:0] IV = {32'h5BE0CD19, 32'h1F83D9AB, 32'h9B05688C, 32'h510E527F,
                                     32'hA54FF53A, 32'h3C6EF372, 32'hBB67AE85, 32'h6A09E667};

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_HASH, S_DONE, S_DRAIN} state_t;

  state_t             r_state, w_nxt;
  logic [4:0]         r_widx, r_blk_cnt;
  logic [6:0]         r_bl;
  logic               r_cs, r_ce, r_root, r_strt, r_err;
  logic [7:0][31:0]   r_h, r_dig;
  logic [15:0][31:0]  r_msg;
  logic               w_beat, w_first, w_bad, w_close, w_wrdy, w_dvld;
  logic [31:0]        w_mask;
  logic [6:0]         w_bl_last;

  assign w_beat    = WVld_I & ((r_state == S_IDLE) | (r_state == S_FILL));
  assign w_first   = (r_state == S_IDLE);
  // A zero-byte final beat is only legal as the whole (empty) message.
  assign w_bad     = w_beat & ((Last_I & (LastBytes_I > 3'd4))
                             | (Last_I & (LastBytes_I == 3'd0) & ~w_first)
                             | (r_blk_cnt == 5'(MAX_BLOCKS)));
  assign w_close   = w_beat & ~w_bad & (Last_I | (r_widx == 5'd15));
  assign w_bl_last = {r_widx, 2'b00} + {4'd0, LastBytes_I};

  always_comb begin
    w_mask = '1;
    if (Last_I) begin
      case (LastBytes_I)
        3'd0:    w_mask = 32'h0000_0000;
        3'd1:    w_mask = 32'h0000_00FF;
        3'd2:    w_mask = 32'h0000_FFFF;
        3'd3:    w_mask = 32'h00FF_FFFF;
        default: w_mask = 32'hFFFF_FFFF;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rstn_I) r_state <= S_IDLE;
    else         r_state <= w_nxt;
  end

  always_comb begin
    w_nxt  = r_state;
    w_wrdy = 1'b0;
    w_dvld = 1'b0;
    case (r_state)
      S_IDLE, S_FILL: begin
        w_wrdy = Rstn_I;
        if (w_bad)        w_nxt = Last_I ? S_IDLE : S_DRAIN;
        else if (w_close) w_nxt = S_HASH;
        else if (w_beat)  w_nxt = S_FILL;
      end
      S_HASH:  if (Vld_I) w_nxt = r_ce ? S_DONE : S_FILL;
      S_DONE: begin
        w_dvld = 1'b1;
        w_nxt  = S_IDLE;
      end
      S_DRAIN: begin
        w_wrdy = Rstn_I;
        if (WVld_I & Last_I) w_nxt = S_IDLE;
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rstn_I) begin
      r_widx    <= '0;
      r_blk_cnt <= '0;
      r_bl      <= '0;
      r_cs      <= 1'b0;
      r_ce      <= 1'b0;
      r_root    <= 1'b0;
      r_strt    <= 1'b0;
      r_err     <= 1'b0;
      r_h       <= IV;
      r_dig     <= '0;
      r_msg     <= '0;
    end else begin
      r_strt <= 1'b0;
      r_err  <= 1'b0;
      if (w_bad) begin
        r_err     <= 1'b1;
        r_h       <= IV;
        r_widx    <= '0;
        r_blk_cnt <= '0;
        r_msg     <= '0;
      end else if (w_beat) begin
        r_msg[r_widx[3:0]] <= Word_I & w_mask;
        r_widx             <= r_widx + 5'd1;
        if (w_close) begin
          r_strt <= 1'b1;
          r_bl   <= Last_I ? w_bl_last : 7'd64;
          r_cs   <= (r_blk_cnt == 5'd0);
          r_ce   <= Last_I;
          r_root <= Last_I;
        end
      end else if ((r_state == S_HASH) && Vld_I) begin
        r_widx <= '0;
        r_msg  <= '0;
        if (r_ce) begin
          r_dig     <= H_I;
          r_h       <= IV;
          r_blk_cnt <= '0;
        end else begin
          r_h       <= H_I;
          r_blk_cnt <= r_blk_cnt + 5'd1;
        end
      end
    end
  end

  assign WRdy_O      = w_wrdy;
  assign Strt_O      = r_strt;
  assign BL_O        = {25'd0, r_bl};
  assign CS_flg_O    = r_cs;
  assign CE_flg_O    = r_ce;
  assign ROOT_flg_O  = r_root;
  assign H_O         = r_h;
  assign Msg_O       = r_msg;
  assign Dig_O       = r_dig;
  assign DVld_O      = w_dvld;
  assign Err_O       = r_err;
  assign Dbg_State_O = r_state;

endmodule

// File: tb/tb_blk3_chunk_sequencer.sv
// Bench for blk3_chunk_sequencer: directed messages, a 50-cycle stub HashGen, and a
// scoreboard of expected blocks, digests and error pulses popped by a monitor.
module tb_blk3_chunk_sequencer;

  localparam int STUB_LAT = 50;
  localparam logic [7:0][31:0] IV = {32'h5BE0CD19, 32'h1F83D9AB, 32'h9B05688C, 32'h510E527F,
                                     32'hA54FF53A, 32'h3C6EF372, 32'hBB67AE85, 32'h6A09E667};

  logic              Clk = 1'b0;
  logic              Rstn_I;
  logic [31:0]       Word_I;
  logic              WVld_I, Last_I;
  logic [2:0]        LastBytes_I;
  logic              WRdy_O, Strt_O, CS_flg_O, CE_flg_O, ROOT_flg_O, DVld_O, Err_O;
  logic [31:0]       BL_O;
  logic [7:0][31:0]  H_O, Dig_O, H_I;
  logic [15:0][31:0] Msg_O;
  logic              Vld_I;
  logic [2:0]        Dbg_State_O;

  typedef struct packed {
    logic [31:0]       bl;
    logic              cs;
    logic              ce;
    logic              root;
    logic [7:0][31:0]  h;
    logic [15:0][31:0] msg;
  } blk_t;

  blk_t         exp_blk_q[$];
  logic [255:0] exp_dig_q[$];
  logic         exp_err_q[$];
  int           n_checks = 0;
  int           n_fail   = 0;
  int           rst_gen  = 0;

  blk3_chunk_sequencer #(.MAX_BLOCKS(16)) dut (
    .Clk(Clk), .Rstn_I(Rstn_I), .Word_I(Word_I), .WVld_I(WVld_I), .Last_I(Last_I),
    .LastBytes_I(LastBytes_I), .WRdy_O(WRdy_O), .Strt_O(Strt_O), .BL_O(BL_O),
    .CS_flg_O(CS_flg_O), .CE_flg_O(CE_flg_O), .ROOT_flg_O(ROOT_flg_O), .H_O(H_O),
    .Msg_O(Msg_O), .Vld_I(Vld_I), .H_I(H_I), .Dig_O(Dig_O), .DVld_O(DVld_O),
    .Err_O(Err_O), .Dbg_State_O(Dbg_State_O)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    n_checks++;
    n_fail++;
    $display("FAIL %s act=event exp=none", nm);
  endtask

  // Stand-in compression: any deterministic mix of all HashGen inputs will do.
  function automatic logic [7:0][31:0] hash_f(input logic [7:0][31:0] h,
      input logic [15:0][31:0] m, input logic [31:0] bl, input logic cs, ce, root);
    logic [7:0][31:0] r;
    for (int i = 0; i < 8; i++)
      r[i] = {h[i][30:0], h[i][31]} ^ m[i] ^ {m[i+8][15:0], m[i+8][31:16]} ^ bl
           ^ (32'h9E3779B9 * 32'(i + 1)) ^ {29'd0, cs, ce, root};
    return r;
  endfunction

  function automatic logic [31:0] byte_mask(input int lb);
    case (lb)
      0:       return 32'h0000_0000;
      1:       return 32'h0000_00FF;
      2:       return 32'h0000_FFFF;
      3:       return 32'h00FF_FFFF;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  task automatic check_reset_vals(input string tag);
    chk({tag, "_wrdy"}, 512'(WRdy_O), 512'(0));
    chk({tag, "_strt"}, 512'(Strt_O), 512'(0));
    chk({tag, "_bl"},   512'(BL_O), 512'(0));
    chk({tag, "_flags"}, 512'({CS_flg_O, CE_flg_O, ROOT_flg_O}), 512'(0));
    chk({tag, "_h"},    512'(H_O), 512'(IV));
    chk({tag, "_msg"},  512'(Msg_O), 512'(0));
    chk({tag, "_dig"},  512'(Dig_O), 512'(0));
    chk({tag, "_pulses"}, 512'({DVld_O, Err_O}), 512'(0));
  endtask

  // Builds the expected block/digest/error sequence, then drives the beats back to back.
  task automatic send_msg(input int nbytes, input int kind, input int lb_ovr, input bit no_digest);
    logic [31:0]      w[0:511];
    logic [7:0][31:0] h;
    blk_t             e;
    int nbeats, lb, err_idx, nblk, cnt, waited;
    bit err, fin, closing;
    nbeats = (nbytes == 0) ? 1 : (nbytes + 3) / 4;
    lb     = (lb_ovr >= 0) ? lb_ovr : nbytes - 4 * (nbeats - 1);
    err    = (nbeats > 256) || (lb > 4) || (lb == 0 && nbeats > 1);
    err_idx = (nbeats > 256) ? 256 : nbeats - 1;
    for (int k = 0; k < nbeats; k++)
      w[k] = (kind == 0) ? 32'hAABBCCDD : (32'h9E3779B9 * 32'(k + 1)) ^ 32'(nbytes);
    h    = IV;
    nblk = err ? err_idx / 16 : (nbeats + 15) / 16;
    for (int b = 0; b < nblk; b++) begin
      cnt = err ? 16 : ((nbeats - 16 * b) > 16 ? 16 : nbeats - 16 * b);
      fin = !err && (b == nblk - 1);
      e.bl   = fin ? 32'(4 * (cnt - 1) + lb) : 32'd64;
      e.cs   = (b == 0);
      e.ce   = fin;
      e.root = fin;
      e.h    = h;
      e.msg  = '0;
      for (int j = 0; j < cnt; j++)
        e.msg[j] = w[16 * b + j] & ((fin && j == cnt - 1) ? byte_mask(lb) : 32'hFFFF_FFFF);
      exp_blk_q.push_back(e);
      h = hash_f(h, e.msg, e.bl, e.cs, e.ce, e.root);
      if (fin && !no_digest) exp_dig_q.push_back(h);
    end
    if (err) exp_err_q.push_back(1'b1);

    for (int i = 0; i < nbeats; i++) begin
      Word_I      = w[i];
      Last_I      = (i == nbeats - 1);
      LastBytes_I = Last_I ? 3'(lb) : 3'($urandom_range(0, 7));
      WVld_I      = 1'b1;
      waited = 0;
      while (!WRdy_O && waited < 500) begin
        @(negedge Clk);
        waited++;
      end
      if (!WRdy_O) begin
        fail_now("wrdy_timeout");
        WVld_I = 1'b0;
        return;
      end
      @(negedge Clk);
      closing = (!err || i < err_idx) && ((i == nbeats - 1) || (i % 16 == 15));
      chk($sformatf("strt_after_beat%0d_len%0d", i, nbytes), 512'(Strt_O), 512'(closing));
    end
    WVld_I = 1'b0;
    Last_I = 1'b0;
    if (!no_digest) begin
      waited = 0;
      while ((exp_blk_q.size() + exp_dig_q.size() + exp_err_q.size()) != 0 && waited < 3000) begin
        @(negedge Clk);
        waited++;
      end
      if (waited >= 3000) fail_now($sformatf("completion_timeout_len%0d", nbytes));
      repeat (3) @(negedge Clk);
    end
  endtask

  // Stub HashGen: fixed latency, checks input stability while the compression is pending.
  initial begin : stub
    blk_t cap;
    int   gen;
    Vld_I = 1'b0;
    H_I   = '0;
    forever begin
      @(negedge Clk);
      if (Strt_O) begin
        cap = '{bl: BL_O, cs: CS_flg_O, ce: CE_flg_O, root: ROOT_flg_O, h: H_O, msg: Msg_O};
        gen = rst_gen;
        repeat (STUB_LAT - 1) @(negedge Clk);
        H_I   = hash_f(cap.h, cap.msg, cap.bl, cap.cs, cap.ce, cap.root);
        Vld_I = 1'b1;
        if (gen == rst_gen) begin
          chk("hold_inputs", 512'({BL_O, CS_flg_O, CE_flg_O, ROOT_flg_O, H_O}),
              512'({cap.bl, cap.cs, cap.ce, cap.root, cap.h}));
          chk("hold_msg", 512'(Msg_O), 512'(cap.msg));
        end
        @(negedge Clk);
        Vld_I = 1'b0;
      end
    end
  end

  initial begin : monitor
    blk_t e;
    forever begin
      @(negedge Clk);
      if (Rstn_I) begin
        if (Strt_O) begin
          chk("wrdy_in_hash", 512'(WRdy_O), 512'(0));
          if (exp_blk_q.size() == 0) fail_now("unexpected_strt");
          else begin
            e = exp_blk_q.pop_front();
            chk("blk_bl", 512'(BL_O), 512'(e.bl));
            chk("blk_flags", 512'({CS_flg_O, CE_flg_O, ROOT_flg_O}), 512'({e.cs, e.ce, e.root}));
            chk("blk_h", 512'(H_O), 512'(e.h));
            chk("blk_msg", 512'(Msg_O), 512'(e.msg));
          end
        end
        if (DVld_O) begin
          if (exp_dig_q.size() == 0) fail_now("unexpected_dvld");
          else chk("digest", 512'(Dig_O), 512'(exp_dig_q.pop_front()));
        end
        if (Err_O) begin
          if (exp_err_q.size() == 0) fail_now("unexpected_err");
          else chk("err_pulse", 512'(Err_O), 512'(exp_err_q.pop_front()));
        end
      end
    end
  end

  initial begin : main
    Rstn_I = 1'b0; WVld_I = 1'b0; Last_I = 1'b0; Word_I = '0; LastBytes_I = '0;
    repeat (3) @(negedge Clk);
    check_reset_vals("reset");
    Rstn_I = 1'b1;
    @(negedge Clk);

    send_msg(0,    1, -1, 1'b0);  // empty message
    send_msg(65,   0, -1, 1'b0);  // 64 + 1 byte, constant word
    send_msg(326,  1, -1, 1'b0);  // header-sized, six blocks
    send_msg(64,   1, -1, 1'b0);  // exact block, no trailing empty block
    send_msg(1028, 1, -1, 1'b0);  // overflow on final beat
    send_msg(4,    1, -1, 1'b0);
    send_msg(1100, 1, -1, 1'b0);  // overflow mid-message, drained
    send_msg(8,    1,  5, 1'b0);  // LastBytes out of range
    send_msg(8,    1,  0, 1'b0);  // zero LastBytes on non-first beat
    send_msg(12,   0, -1, 1'b0);

    send_msg(64, 1, -1, 1'b1);    // leaves DUT waiting on HashGen
    repeat (10) @(negedge Clk);
    chk("in_hash_before_reset", 512'(Dbg_State_O), 512'(2));
    Rstn_I = 1'b0;
    rst_gen++;
    @(negedge Clk);
    check_reset_vals("midhash_reset");
    Rstn_I = 1'b1;
    repeat (STUB_LAT + 10) @(negedge Clk);
    chk("late_vld_state", 512'(Dbg_State_O), 512'(0));
    chk("late_vld_h", 512'(H_O), 512'(IV));
    chk("late_vld_dig", 512'(Dig_O), 512'(0));
    send_msg(4, 1, -1, 1'b0);

    chk("queues_empty", 512'(exp_blk_q.size() + exp_dig_q.size() + exp_err_q.size()), 512'(0));
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
